// File: rtl/ram_arbiter_pkg.sv
// Shared params for the RAM arbiter: widths, port count and FSM state encoding.
package ram_arbiter_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned BUS_WIDTH     = 8;
  localparam int unsigned NUM_ARB_PORTS = 2;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t ACCESS = 2'd1;
  localparam arb_state_t RDWAIT = 2'd2;

  function automatic logic [NUM_ARB_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// arb_pick: combinational one-hot winner select between core and loader.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise the core always wins.
module arb_pick import ram_arbiter_pkg::*; (
  input  logic [NUM_ARB_PORTS-1:0] req,
  input  logic                     last,
  output logic [NUM_ARB_PORTS-1:0] winner
);

`ifdef ARB_ROUND_ROBIN_EN
  // last is the most recently granted port; the other one wins a tie
  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic last_unused;
  assign last_unused = last;

  always_comb begin
    winner = req;
    if (req[0]) begin
      winner = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serializes core (port 0) and loader (port 1) accesses onto one RAM.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed core priority.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = ram_arbiter_pkg::DATA_WIDTH,
  parameter int unsigned BUS_WIDTH  = ram_arbiter_pkg::BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [BUS_WIDTH-1:0]  addr0,
  input  logic [BUS_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic [BUS_WIDTH-1:0]  ram_addr_rd,
  output logic [BUS_WIDTH-1:0]  ram_addr_wr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_rd
);
  import ram_arbiter_pkg::*;

  arb_state_t            state;
  arb_state_t            state_next;
  logic [1:0]            winner;
  logic                  hold_port;
  logic                  last;
  logic                  sel_we;
  logic [BUS_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  arb_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // hold_port is loaded on every grant, so it doubles as the round-robin pointer
  assign last = hold_port;
`else
  assign last = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign sel_we    = winner[1] ? we[1]  : we[0];
  assign sel_addr  = winner[1] ? addr1  : addr0;
  assign sel_wdata = winner[1] ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the combinational grant pulse
  always_comb begin
    state_next = state;
    gnt        = 2'b00;
    case (state)
      IDLE: begin
        if (!rst && (req != 2'b00)) begin
          gnt        = winner;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = ram_wr_en ? IDLE : RDWAIT;
      RDWAIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM drive registers act as the holding registers; live only during ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_port   <= 1'b0;
      rvalid      <= 2'b00;
      rdata       <= '0;
      ram_rd_en   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr_rd <= '0;
      ram_addr_wr <= '0;
      ram_data_wr <= '0;
    end else begin
      rvalid      <= 2'b00;
      ram_rd_en   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr_rd <= '0;
      ram_addr_wr <= '0;
      ram_data_wr <= '0;
      if (gnt != 2'b00) begin
        hold_port   <= winner[1];
        ram_wr_en   <= sel_we;
        ram_rd_en   <= !sel_we;
        ram_addr_wr <= sel_we ? sel_addr  : '0;
        ram_addr_rd <= sel_we ? '0        : sel_addr;
        ram_data_wr <= sel_we ? sel_wdata : '0;
      end
      if (state == RDWAIT) begin
        rdata  <= ram_data_rd;
        rvalid <= port_onehot(hold_port);
      end
    end
  end

endmodule
